pipe_fetch_stage: RTL and testbench

Instruction-fetch stage plus IF/ID pipeline register of the five-stage pipelined computer. It sits directly upstream of the ID stage. It owns the PC, selects the next PC from the ID stage's `pcsource`/`bpc`/`jpc`/`da` outputs, and fetches from a wait-state-capable instruction memory. It presents `inst`/`dpc4` to ID and honours `nostall` and the MIPS single branch delay slot.

---
 rtl/pipe_fetch_stage.sv | 122 ++++++++++++
 tb/tb_pipe_fetch_stage.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/pipe_fetch_stage.sv
// Instruction-fetch stage with IF/ID register: owns the PC, fetches from a wait-state memory,
// and honours ID stalls and the single branch delay slot.
module pipe_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        nostall,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] jpc,
  input  logic [31:0] da,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [31:0] pc,
  output logic [31:0] inst,
  output logic [31:0] dpc4,
  output logic        dvalid
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] dpc4_q, dpc4_d;
  logic        dvalid_q, dvalid_d;
  logic        bufv_q, bufv_d;
  logic [31:0] buf_inst_q, buf_inst_d;
  logic        redir_q, redir_d;
  logic [31:0] rtarget_q, rtarget_d;

  logic        fire;
  logic        avail;
  logic [31:0] word;
  logic [31:0] pc_plus4;
  logic [31:0] tgt;
  logic        take;

  // Handshake: a fetch completes only in a cycle where imem_req and imem_ack are both high;
  // imem_addr stays at pc until then, and an ack seen without a request is ignored.
  assign imem_req  = !rst && !bufv_q;
  assign imem_addr = pc_q;
  assign fire      = imem_ack && imem_req;
  assign avail     = bufv_q || fire;
  assign word      = bufv_q ? buf_inst_q : imem_rdata;
  assign pc_plus4  = pc_q + 32'd4;

  always_comb begin
    tgt = pc_plus4;
    case (pcsource)
      2'b01:   tgt = bpc;
      2'b10:   tgt = da;
      2'b11:   tgt = jpc;
      default: tgt = pc_plus4;
    endcase
  end

  // A bubble in ID carries no control transfer, so its pcsource is ignored.
  assign take = nostall && dvalid_q && (pcsource != 2'b00);

  always_comb begin
    pc_d       = pc_q;
    inst_d     = inst_q;
    dpc4_d     = dpc4_q;
    dvalid_d   = dvalid_q;
    bufv_d     = bufv_q;
    buf_inst_d = buf_inst_q;
    redir_d    = redir_q;
    rtarget_d  = rtarget_q;
    if (nostall) begin
      if (avail) begin
        inst_d   = word;
        dpc4_d   = pc_plus4;
        dvalid_d = 1'b1;
        bufv_d   = 1'b0;
        redir_d  = 1'b0;
        if (redir_q)   pc_d = rtarget_q;
        else if (take) pc_d = tgt;
        else           pc_d = pc_plus4;
      end else begin
        inst_d   = 32'd0;
        dvalid_d = 1'b0;
        // Branch leaves ID before its delay slot arrives: remember where to go afterwards.
        if (take) begin
          redir_d   = 1'b1;
          rtarget_d = tgt;
        end
      end
    end else if (fire) begin
      bufv_d     = 1'b1;
      buf_inst_d = imem_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      inst_q     <= 32'd0;
      dpc4_q     <= 32'd0;
      dvalid_q   <= 1'b0;
      bufv_q     <= 1'b0;
      buf_inst_q <= 32'd0;
      redir_q    <= 1'b0;
      rtarget_q  <= 32'd0;
    end else begin
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      dpc4_q     <= dpc4_d;
      dvalid_q   <= dvalid_d;
      bufv_q     <= bufv_d;
      buf_inst_q <= buf_inst_d;
      redir_q    <= redir_d;
      rtarget_q  <= rtarget_d;
    end
  end

  assign pc     = pc_q;
  assign inst   = inst_q;
  assign dpc4   = dpc4_q;
  assign dvalid = dvalid_q;

endmodule

// File: tb/tb_pipe_fetch_stage.sv
// Directed bench for pipe_fetch_stage: a per-cycle vector table plus a hand-written
// reset-mid-wait sequence. Memory returns word = address whenever ack is driven.
module tb_pipe_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        nostall;
  logic [1:0]  pcsource;
  logic [31:0] bpc, jpc, da;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic [31:0] pc, inst, dpc4;
  logic        dvalid;

  int errors = 0;
  int checks = 0;

  pipe_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .nostall(nostall), .pcsource(pcsource),
    .bpc(bpc), .jpc(jpc), .da(da),
    .imem_addr(imem_addr), .imem_req(imem_req), .imem_rdata(imem_rdata),
    .imem_ack(imem_ack), .pc(pc), .inst(inst), .dpc4(dpc4), .dvalid(dvalid)
  );

  always #5 clk = ~clk;

  // Garbage when no ack, so a design that reads the bus instead of its buffer shows up.
  assign imem_rdata = imem_ack ? imem_addr : 32'hDEAD_BEEF;

  typedef struct {
    logic        ns;
    logic [1:0]  src;
    logic [31:0] tv;
    logic        ack;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic [31:0] e_dpc4;
    logic        e_dv;
    logic        e_req;
  } vec_t;

  localparam int NV = 27;
  vec_t vecs[NV];

  function automatic vec_t mk(logic ns, logic [1:0] src, logic [31:0] tv, logic ack,
                              logic [31:0] e_pc, logic [31:0] e_inst, logic [31:0] e_dpc4,
                              logic e_dv, logic e_req);
    vec_t v;
    v.ns = ns; v.src = src; v.tv = tv; v.ack = ack;
    v.e_pc = e_pc; v.e_inst = e_inst; v.e_dpc4 = e_dpc4; v.e_dv = e_dv; v.e_req = e_req;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_inst,
                         input logic [31:0] e_dpc4, input logic e_dv, input logic e_req);
    chk({tag, " pc"}, pc, e_pc);
    chk({tag, " inst"}, inst, e_inst);
    chk({tag, " dpc4"}, dpc4, e_dpc4);
    chk({tag, " dvalid"}, {31'd0, dvalid}, {31'd0, e_dv});
    chk({tag, " imem_req"}, {31'd0, imem_req}, {31'd0, e_req});
  endtask

  // Unselected targets carry distinct decoys so a wrong mux leg is visible.
  task automatic drive(input logic ns, input logic [1:0] src, input logic [31:0] tv, input logic ack);
    nostall  = ns;
    pcsource = src;
    bpc      = (src == 2'b01) ? tv : 32'h1111_1110;
    da       = (src == 2'b10) ? tv : 32'h2222_2220;
    jpc      = (src == 2'b11) ? tv : 32'h3333_3330;
    imem_ack = ack;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b1, 2'b00, 32'd0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all("reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    // ns src target ack | pc inst dpc4 dvalid req (state after the edge)
    vecs[0]  = mk(1, 2'd0, 32'h0,        1, 32'h4,         32'h0,         32'h4,      1, 1);
    vecs[1]  = mk(1, 2'd0, 32'h0,        1, 32'h8,         32'h4,         32'h8,      1, 1);
    vecs[2]  = mk(1, 2'd0, 32'h0,        1, 32'hC,         32'h8,         32'hC,      1, 1);
    vecs[3]  = mk(1, 2'd0, 32'h0,        1, 32'h10,        32'hC,         32'h10,     1, 1);
    vecs[4]  = mk(1, 2'd0, 32'h0,        1, 32'h14,        32'h10,        32'h14,     1, 1);
    vecs[5]  = mk(1, 2'd1, 32'h100,      1, 32'h100,       32'h14,        32'h18,     1, 1);
    vecs[6]  = mk(1, 2'd0, 32'h0,        1, 32'h104,       32'h100,       32'h104,    1, 1);
    vecs[7]  = mk(1, 2'd0, 32'h0,        1, 32'h108,       32'h104,       32'h108,    1, 1);
    vecs[8]  = mk(1, 2'd1, 32'h200,      0, 32'h108,       32'h0,         32'h108,    0, 1);
    vecs[9]  = mk(1, 2'd1, 32'h300,      0, 32'h108,       32'h0,         32'h108,    0, 1);
    vecs[10] = mk(1, 2'd1, 32'h300,      0, 32'h108,       32'h0,         32'h108,    0, 1);
    vecs[11] = mk(1, 2'd1, 32'h300,      1, 32'h200,       32'h108,       32'h10C,    1, 1);
    vecs[12] = mk(1, 2'd0, 32'h0,        1, 32'h204,       32'h200,       32'h204,    1, 1);
    vecs[13] = mk(0, 2'd0, 32'h0,        1, 32'h204,       32'h200,       32'h204,    1, 0);
    vecs[14] = mk(0, 2'd0, 32'h0,        1, 32'h204,       32'h200,       32'h204,    1, 0);
    vecs[15] = mk(0, 2'd0, 32'h0,        1, 32'h204,       32'h200,       32'h204,    1, 0);
    vecs[16] = mk(0, 2'd0, 32'h0,        1, 32'h204,       32'h200,       32'h204,    1, 0);
    vecs[17] = mk(1, 2'd0, 32'h0,        0, 32'h208,       32'h204,       32'h208,    1, 1);
    vecs[18] = mk(1, 2'd0, 32'h0,        1, 32'h20C,       32'h208,       32'h20C,    1, 1);
    vecs[19] = mk(1, 2'd2, 32'h2000,     1, 32'h2000,      32'h20C,       32'h210,    1, 1);
    vecs[20] = mk(1, 2'd0, 32'h0,        1, 32'h2004,      32'h2000,      32'h2004,   1, 1);
    vecs[21] = mk(1, 2'd3, 32'h40_0000,  1, 32'h40_0000,   32'h2004,      32'h2008,   1, 1);
    vecs[22] = mk(1, 2'd0, 32'h0,        1, 32'h40_0004,   32'h40_0000,   32'h40_0004, 1, 1);
    vecs[23] = mk(1, 2'd3, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 32'h40_0004,  32'h40_0008, 1, 1);
    vecs[24] = mk(1, 2'd0, 32'h0,        1, 32'h0,         32'hFFFF_FFFC, 32'h0,      1, 1);
    vecs[25] = mk(0, 2'd1, 32'h500,      0, 32'h0,         32'hFFFF_FFFC, 32'h0,      1, 1);
    vecs[26] = mk(1, 2'd0, 32'h0,        1, 32'h4,         32'h0,         32'h4,      1, 1);

    do_reset();
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].ns, vecs[i].src, vecs[i].tv, vecs[i].ack);
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_inst, vecs[i].e_dpc4,
              vecs[i].e_dv, vecs[i].e_req);
      @(negedge clk);
    end

    // Reset pulsed while a fetch at 0x80 is waiting.
    do_reset();
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 2'b00, 32'd0, 1'b1);
      @(negedge clk);
    end
    drive(1'b1, 2'b00, 32'd0, 1'b0);
    @(posedge clk);
    #1;
    chk_all("wait", 32'h80, 32'h0, 32'h80, 1'b0, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk_all("async_rst", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    imem_ack = 1'b1;
    @(posedge clk);
    #1;
    chk_all("ack_in_rst", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 2'b00, 32'd0, 1'b1);
    @(posedge clk);
    #1;
    chk_all("restart0", 32'h4, 32'h0, 32'h4, 1'b1, 1'b1);
    @(negedge clk);
    @(posedge clk);
    #1;
    chk_all("restart1", 32'h8, 32'h4, 32'h8, 1'b1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
